gauss_filter_ctrl: RTL

GAUSS_FILTER_CTRL -- requirements
Module: gauss_filter_ctrl

---
 rtl/gauss_filter_pkg.sv | 18 +
 rtl/gauss_filter_addrgen.sv | 57 +++++
 rtl/gauss_filter_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gauss_filter_pkg.sv
// Shared definitions for the two-pass Gaussian filter controller:
// FSM state encoding, default image geometry and coordinate width.
package gauss_filter_pkg;

    localparam int unsigned IMG_W_DEF = 256;
    localparam int unsigned IMG_H_DEF = 256;
    localparam int unsigned COORD_W   = 10;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StStart = 3'd1;
    localparam state_t StPass0 = 3'd2;
    localparam state_t StPass1 = 3'd3;
    localparam state_t StFin   = 3'd4;
    localparam state_t StErr   = 3'd5;

endpackage

// File: rtl/gauss_filter_addrgen.sv
// Column/row pixel counters for one filter pass plus the transpose mux
// that turns the row scan into a column write-back in the second pass.
module gauss_filter_addrgen
    import gauss_filter_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    input  logic               transpose,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               last
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] ColMax = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowMax = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (col_q == ColMax) begin
                col_d = '0;
                row_d = (row_q == RowMax) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign last = (col_q == ColMax) && (row_q == RowMax);
    assign px   = transpose ? COORD_W'(row_q) : COORD_W'(col_q);
    assign py   = transpose ? COORD_W'(col_q) : COORD_W'(row_q);

endmodule

// File: rtl/gauss_filter_ctrl.sv
// Frame controller for a separable Gaussian filter: row pass into the dest
// ram, then a transposed pass back into the source ram, with a watchdog.
module gauss_filter_ctrl
    import gauss_filter_pkg::*;
#(
    parameter int unsigned IMG_W    = IMG_W_DEF,
    parameter int unsigned IMG_H    = IMG_H_DEF,
    parameter int unsigned WDOG_MAX = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic               rd_start,
    input  logic               flt_vld,
    output logic               wr_en,
    output logic               wr_sel,
    output logic [COORD_W-1:0] wr_px,
    output logic [COORD_W-1:0] wr_py,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned WW = $clog2(WDOG_MAX + 1);
    localparam logic [WW-1:0] WdogLast = WW'(WDOG_MAX - 1);

    state_t             state_q, state_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic               err_q, err_d;
    logic               rd_start_q, wr_en_q, wr_sel_q;
    logic [COORD_W-1:0] wr_px_q, wr_py_q;
    logic [COORD_W-1:0] ag_px, ag_py;
    logic               ag_last;
    logic               in_pass, accept, adv;

    assign in_pass = (state_q == StPass0) || (state_q == StPass1);
    assign accept  = cmd_valid && (state_q == StIdle);
    assign adv     = in_pass && flt_vld;

    gauss_filter_addrgen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addrgen (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .adv       (adv),
        .transpose (state_q == StPass1),
        .px        (ag_px),
        .py        (ag_py),
        .last      (ag_last)
    );

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    wdog_d  = '0;
                    err_d   = 1'b0;
                end
            end
            StStart: state_d = StPass0;
            StPass0, StPass1: begin
                // A pixel arriving on the expiry cycle still wins over the watchdog.
                if (flt_vld) begin
                    wdog_d = '0;
                    if (ag_last) begin
                        state_d = (state_q == StPass0) ? StPass1 : StFin;
                    end
                end else begin
                    wdog_d = wdog_q + WW'(1);
                    if (wdog_q == WdogLast) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            rd_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_px_q    <= '0;
            wr_py_q    <= '0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            rd_start_q <= (state_q == StStart);
            wr_en_q    <= adv;
            if (adv) begin
                wr_sel_q <= (state_q == StPass1);
                wr_px_q  <= ag_px;
                wr_py_q  <= ag_py;
            end
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err       = err_q;
    assign rd_start  = rd_start_q;
    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_px     = wr_px_q;
    assign wr_py     = wr_py_q;

endmodule
